cfg_loader: RTL
===============

CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 69, giving the number of bits in the target configuration shift chain.
REQ-002 SHALL have parameter WORD_W, default 32, giving the width of each bitstream word accepted from the host.
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin programming.
REQ-006 SHALL have port wr_data, input, WORD_W bits: bitstream word, shifted out LSB first.
REQ-007 SHALL have port wr_valid, input, 1 bit: wr_data is valid.
REQ-008 SHALL have port wr_ready, output, 1 bit: the loader accepts wr_data this cycle.
REQ-009 SHALL have port prog_out, output, 1 bit: serial data to the chain's prog_in.
REQ-010 SHALL have port prog_en, output, 1 bit: shift enable to the chain.
REQ-011 SHALL have port chain_ret, input, 1 bit: the chain's serial prog_out, used only for readback.
REQ-012 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when programming completes.
REQ-014 SHALL have port err, output, 1 bit: sticky readback mismatch flag.

Function
REQ-015 SHALL implement states IDLE, LOAD, VERIFY (readback build only) and DONE.
REQ-016 In IDLE, start=1 SHALL move the FSM to LOAD, assert busy and clear the bit counter and err.
REQ-017 In LOAD, wr_ready SHALL be 1 only while the word shift register is empty and bits remain to be sent.
REQ-018 A word SHALL be accepted at an edge where wr_valid and wr_ready are both 1; bit 0 appears on prog_out with prog_en=1 in the following cycle.
REQ-019 SHALL present one bit per cycle, LSB first; prog_en=1 exactly in cycles holding a valid bit, one chain shift per such cycle.
REQ-020 If the word register is empty and wr_valid=0, prog_en SHALL be 0 (stall); no bit is lost or duplicated.
REQ-021 When one word empties while the next is offered the same cycle, SHALL accept it back to back with no gap.
REQ-022 SHALL shift exactly CHAIN_LEN bits, consuming ceil(CHAIN_LEN/WORD_W) words (3 at defaults); unused upper bits of the last word are discarded.
REQ-023 After the CHAIN_LEN-th bit: without readback go to DONE; with readback go to VERIFY.
REQ-024 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE.
REQ-025 start SHALL be ignored while busy=1; wr_data SHALL be ignored outside LOAD (wr_ready=0).
REQ-026 The bit counter SHALL be wide enough for CHAIN_LEN and never wrap within a pass.

Reset
REQ-027 rst=1 SHALL, at the next edge, force IDLE and clear counters and the word register.
REQ-028 After reset, prog_out, prog_en, wr_ready, busy, done and err SHALL all be 0.
REQ-029 rst mid-LOAD or mid-VERIFY SHALL drop prog_en the following cycle; a new start is needed to reprogram.

Configuration
REQ-030 Macro CFG_LOADER_READBACK_EN SHALL enable readback; without it, VERIFY, its copy register and compare logic are absent, and err is tied to 0.
REQ-031 With the macro, SHALL store all CHAIN_LEN bits sent in LOAD in a copy register.
REQ-032 In VERIFY, SHALL re-shift the copy, LSB first with prog_en=1 for CHAIN_LEN consecutive cycles, restoring chain contents.
REQ-033 In VERIFY, at the k-th shift SHALL compare chain_ret with copy bit k and set err on any mismatch; err holds until next start or rst.

Verification
REQ-034 start, then words 0xDEADBEEF, 0x12345678, 0x0000001F back to back -> 69 consecutive prog_en cycles; 69-bit model chain holds {5'h1F, 0x12345678, 0xDEADBEEF}; done pulses once.
REQ-035 Same words with wr_valid dropped 3 cycles after each word -> prog_en low exactly in stall cycles; chain contents identical to REQ-034.
REQ-036 start asserted again mid-LOAD and wr_valid before start -> both ignored, 3 words consumed, wr_ready stays 0 in IDLE.
REQ-037 rst asserted after 40 bits -> next cycle prog_en=0, busy=0, all outputs 0; new start then loads 69 fresh bits correctly.
REQ-038 CFG_LOADER_READBACK_EN, ideal 69-bit chain -> 138 prog_en cycles, err=0, chain unchanged; with chain bit 10 forced stuck-at-0 and source bit 10 = 1 -> err=1 at done.

Source files
------------

// File: rtl/cfg_loader.sv
// Serial configuration loader: streams CHAIN_LEN bits from host words into a shift chain, LSB first.
// Optional readback/verify pass is enabled by defining CFG_LOADER_READBACK_EN.
module cfg_loader #(
  parameter int CHAIN_LEN = 69,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              prog_out,
  output logic              prog_en,
  input  logic              chain_ret,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int PEND_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
`ifdef CFG_LOADER_READBACK_EN
    VERIFY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t            state_r;
  logic [WORD_W-1:0] word_r;
  logic [PEND_W-1:0] pend_r;
  logic [CNT_W-1:0]  sent_r;
  logic              prog_out_r;
  logic              prog_en_r;
  logic              wr_ready_r;
  logic              busy_r;
  logic              done_r;
  logic [31:0]       rem_s;
  logic [31:0]       take_s;
  logic              last_bit_s;

`ifdef CFG_LOADER_READBACK_EN
  logic [CHAIN_LEN-1:0] copy_r;
  logic                 err_r;
`endif

  // Bits still owed to the chain, bits the next word contributes, and whether the next bit is the final one
  always_comb begin
    rem_s = 32'(CHAIN_LEN) - 32'(sent_r);
    if (rem_s > 32'(WORD_W)) begin
      take_s = 32'(WORD_W);
    end else begin
      take_s = rem_s;
    end
    last_bit_s = (32'(sent_r) + 32'd1) >= 32'(CHAIN_LEN);
  end

  // Loader FSM; prog_out holds the bit being shifted, word_r holds the bits of the current word still pending
  always_ff @(posedge prog_clk) begin
    if (rst) begin
      state_r    <= IDLE;
      word_r     <= '0;
      pend_r     <= '0;
      sent_r     <= '0;
      prog_out_r <= 1'b0;
      prog_en_r  <= 1'b0;
      wr_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef CFG_LOADER_READBACK_EN
      copy_r     <= '0;
      err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r    <= 1'b0;
          prog_en_r <= 1'b0;
          if (start) begin
            state_r    <= LOAD;
            busy_r     <= 1'b1;
            sent_r     <= '0;
            pend_r     <= '0;
            wr_ready_r <= 1'b1;
`ifdef CFG_LOADER_READBACK_EN
            err_r      <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (pend_r != '0) begin
            prog_out_r <= word_r[0];
            word_r     <= word_r >> 1;
            pend_r     <= pend_r - PEND_W'(1);
            sent_r     <= sent_r + CNT_W'(1);
            prog_en_r  <= 1'b1;
            // Ready rises while the last pending bit is on the wire so the next word follows with no gap
            wr_ready_r <= (pend_r == PEND_W'(1)) && !last_bit_s;
`ifdef CFG_LOADER_READBACK_EN
            copy_r[sent_r] <= word_r[0];
`endif
          end else if (32'(sent_r) >= 32'(CHAIN_LEN)) begin
            wr_ready_r <= 1'b0;
`ifdef CFG_LOADER_READBACK_EN
            state_r    <= VERIFY;
            prog_out_r <= copy_r[0];
            prog_en_r  <= 1'b1;
            sent_r     <= CNT_W'(1);
`else
            state_r    <= DONE;
            prog_out_r <= 1'b0;
            prog_en_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
`endif
          end else if (wr_valid && wr_ready_r) begin
            prog_out_r <= wr_data[0];
            word_r     <= wr_data >> 1;
            pend_r     <= PEND_W'(take_s - 32'd1);
            sent_r     <= sent_r + CNT_W'(1);
            prog_en_r  <= 1'b1;
            wr_ready_r <= (take_s == 32'd1) && !last_bit_s;
`ifdef CFG_LOADER_READBACK_EN
            copy_r[sent_r] <= wr_data[0];
`endif
          end else begin
            prog_en_r <= 1'b0;
          end
        end
`ifdef CFG_LOADER_READBACK_EN
        VERIFY: begin
          // chain_ret carries original bit k while copy bit k is being shifted back in
          if (chain_ret != prog_out_r) begin
            err_r <= 1'b1;
          end
          if (32'(sent_r) >= 32'(CHAIN_LEN)) begin
            state_r    <= DONE;
            prog_out_r <= 1'b0;
            prog_en_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
          end else begin
            prog_out_r <= copy_r[sent_r];
            sent_r     <= sent_r + CNT_W'(1);
            prog_en_r  <= 1'b1;
          end
        end
`endif
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          prog_en_r  <= 1'b0;
          wr_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready = wr_ready_r;
  assign prog_out = prog_out_r;
  assign prog_en  = prog_en_r;
  assign busy     = busy_r;
  assign done     = done_r;

`ifdef CFG_LOADER_READBACK_EN
  assign err = err_r;
`else
  logic unused_chain_ret;
  assign unused_chain_ret = chain_ret;
  assign err = 1'b0;
`endif

endmodule
